// File: rtl/fpu_pkg.sv
// Shared FPU definitions: op encoding, output-stage states, class-mask bits.
// Consumed by sign_inject_pipe and fp_classify.
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_SGNJ  = 2'b00,
        OP_SGNJN = 2'b01,
        OP_SGNJX = 2'b10,
        OP_CLASS = 2'b11
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b01,
        ST_FULL  = 2'b10
    } ostage_e;

    localparam int CLS_W        = 10;
    localparam int CLS_NEG_INF  = 0;
    localparam int CLS_NEG_NORM = 1;
    localparam int CLS_NEG_SUB  = 2;
    localparam int CLS_NEG_ZERO = 3;
    localparam int CLS_POS_ZERO = 4;
    localparam int CLS_POS_SUB  = 5;
    localparam int CLS_POS_NORM = 6;
    localparam int CLS_POS_INF  = 7;
    localparam int CLS_SNAN     = 8;
    localparam int CLS_QNAN     = 9;

endpackage

// File: rtl/fp_classify.sv
// Combinational RISC-V FCLASS mask for a parametrised IEEE-style operand.
// Only instantiated when SIGN_INJECT_CLASS_EN is defined.
module fp_classify
    import fpu_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 24
) (
    input  logic [EXP_WIDTH+MANT_WIDTH-1:0] op_i,
    output logic [CLS_W-1:0]                mask_o
);

    localparam int W  = EXP_WIDTH + MANT_WIDTH;
    localparam int FW = MANT_WIDTH - 1;

    logic                 sign;
    logic [EXP_WIDTH-1:0] expo;
    logic [FW-1:0]        frac;
    logic                 exp_max;
    logic                 exp_zero;
    logic                 frac_zero;

    assign sign      = op_i[W-1];
    assign expo      = op_i[W-2 -: EXP_WIDTH];
    assign frac      = op_i[FW-1:0];
    assign exp_max   = &expo;
    assign exp_zero  = ~|expo;
    assign frac_zero = ~|frac;

    // The MSB of the stored fraction is the quiet bit for NaNs.
    always_comb begin
        mask_o = '0;
        if (exp_max && !frac_zero) begin
            if (frac[FW-1]) mask_o[CLS_QNAN] = 1'b1;
            else            mask_o[CLS_SNAN] = 1'b1;
        end else if (exp_max) begin
            if (sign) mask_o[CLS_NEG_INF] = 1'b1;
            else      mask_o[CLS_POS_INF] = 1'b1;
        end else if (exp_zero && frac_zero) begin
            if (sign) mask_o[CLS_NEG_ZERO] = 1'b1;
            else      mask_o[CLS_POS_ZERO] = 1'b1;
        end else if (exp_zero) begin
            if (sign) mask_o[CLS_NEG_SUB] = 1'b1;
            else      mask_o[CLS_POS_SUB] = 1'b1;
        end else begin
            if (sign) mask_o[CLS_NEG_NORM] = 1'b1;
            else      mask_o[CLS_POS_NORM] = 1'b1;
        end
    end

endmodule

// File: rtl/sign_inject_pipe.sv
// FP sign-injection unit with 1-cycle latency and a 2-entry skid output stage.
// Define SIGN_INJECT_CLASS_EN to enable the FCLASS op (op 11).
module sign_inject_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 24,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [EXP_WIDTH+MANT_WIDTH-1:0] in_a,
    input  logic [EXP_WIDTH+MANT_WIDTH-1:0] in_b,
    input  logic [1:0]                      in_op,
    input  logic [TAG_WIDTH-1:0]            in_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [EXP_WIDTH+MANT_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]            out_tag,
    output logic                            out_illegal
);

    localparam int W = EXP_WIDTH + MANT_WIDTH;

    ostage_e              state_q, state_d;
    logic [W-1:0]         main_res_q, main_res_d;
    logic [TAG_WIDTH-1:0] main_tag_q, main_tag_d;
    logic                 main_ill_q, main_ill_d;
    logic [W-1:0]         skid_res_q, skid_res_d;
    logic [TAG_WIDTH-1:0] skid_tag_q, skid_tag_d;
    logic                 skid_ill_q, skid_ill_d;

    logic [W-1:0] new_res;
    logic         new_ill;
    logic         push;
    logic         pop;
    logic         unused_b;

    // Only the sign of b is consumed.
    assign unused_b = ^in_b[W-2:0];

`ifdef SIGN_INJECT_CLASS_EN
    logic [CLS_W-1:0] cls_mask;

    fp_classify #(
        .EXP_WIDTH  (EXP_WIDTH),
        .MANT_WIDTH (MANT_WIDTH)
    ) u_classify (
        .op_i   (in_a),
        .mask_o (cls_mask)
    );
`endif

    always_comb begin
        new_res = '0;
        new_ill = 1'b0;
        unique case (fpu_op_e'(in_op))
            OP_SGNJ:  new_res = {in_b[W-1], in_a[W-2:0]};
            OP_SGNJN: new_res = {~in_b[W-1], in_a[W-2:0]};
            OP_SGNJX: new_res = {in_a[W-1] ^ in_b[W-1], in_a[W-2:0]};
            OP_CLASS: begin
`ifdef SIGN_INJECT_CLASS_EN
                new_res = W'(cls_mask);
`else
                new_ill = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign in_ready    = (state_q != ST_FULL);
    assign out_valid   = (state_q != ST_EMPTY);
    assign out_result  = main_res_q;
    assign out_tag     = main_tag_q;
    assign out_illegal = main_ill_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        main_res_d = main_res_q;
        main_tag_d = main_tag_q;
        main_ill_d = main_ill_q;
        skid_res_d = skid_res_q;
        skid_tag_d = skid_tag_q;
        skid_ill_d = skid_ill_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d    = ST_HALF;
                    main_res_d = new_res;
                    main_tag_d = in_tag;
                    main_ill_d = new_ill;
                end
            end
            ST_HALF: begin
                if (push && pop) begin
                    main_res_d = new_res;
                    main_tag_d = in_tag;
                    main_ill_d = new_ill;
                end else if (push) begin
                    state_d    = ST_FULL;
                    skid_res_d = new_res;
                    skid_tag_d = in_tag;
                    skid_ill_d = new_ill;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a pop can occur.
                if (pop) begin
                    state_d    = ST_HALF;
                    main_res_d = skid_res_q;
                    main_tag_d = skid_tag_q;
                    main_ill_d = skid_ill_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_res_q <= '0;
            main_tag_q <= '0;
            main_ill_q <= 1'b0;
            skid_res_q <= '0;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_res_q <= main_res_d;
            main_tag_q <= main_tag_d;
            main_ill_q <= main_ill_d;
            skid_res_q <= skid_res_d;
            skid_tag_q <= skid_tag_d;
            skid_ill_q <= skid_ill_d;
        end
    end

endmodule

// File: tb/tb_sign_inject_pipe.sv
// Randomised scoreboard bench for sign_inject_pipe plus a double-width instance.
// Honours SIGN_INJECT_CLASS_EN for the op 11 expectations.
module tb_sign_inject_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [1:0]  in_op = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic        out_illegal;

    logic        d_in_valid = 1'b0;
    logic        d_in_ready;
    logic [63:0] d_in_a = '0;
    logic [63:0] d_in_b = '0;
    logic [1:0]  d_in_op = '0;
    logic [3:0]  d_in_tag = '0;
    logic        d_out_valid;
    logic [63:0] d_out_result;
    logic [3:0]  d_out_tag;
    logic        d_out_illegal;

    always #5 clk = ~clk;

    sign_inject_pipe #(
        .EXP_WIDTH (8), .MANT_WIDTH (24), .TAG_WIDTH (4)
    ) dut (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (in_ready),
        .in_a (in_a), .in_b (in_b), .in_op (in_op), .in_tag (in_tag),
        .out_valid (out_valid), .out_ready (out_ready),
        .out_result (out_result), .out_tag (out_tag),
        .out_illegal (out_illegal)
    );

    sign_inject_pipe #(
        .EXP_WIDTH (11), .MANT_WIDTH (53), .TAG_WIDTH (4)
    ) dut_dbl (
        .clk (clk), .rst (rst),
        .in_valid (d_in_valid), .in_ready (d_in_ready),
        .in_a (d_in_a), .in_b (d_in_b), .in_op (d_in_op), .in_tag (d_in_tag),
        .out_valid (d_out_valid), .out_ready (1'b1),
        .out_result (d_out_result), .out_tag (d_out_tag),
        .out_illegal (d_out_illegal)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FCLASS by value category.
    function automatic logic [9:0] cls(input logic [31:0] x);
        logic        s;
        int unsigned e;
        int unsigned f;
        s = x[31];
        e = x[30:23];
        f = x[22:0];
        if (e == 255 && f != 0) return (f >= 32'h400000) ? 10'h200 : 10'h100;
        if (e == 255)           return s ? 10'h001 : 10'h080;
        if (e == 0 && f == 0)   return s ? 10'h008 : 10'h010;
        if (e == 0)             return s ? 10'h004 : 10'h020;
        return s ? 10'h002 : 10'h040;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] op, input logic [3:0] tag);
        exp_t e;
        e.tag = tag;
        e.ill = 1'b0;
        e.res = '0;
        case (op)
            2'd0: e.res = {b[31], a[30:0]};
            2'd1: e.res = {~b[31], a[30:0]};
            2'd2: e.res = {a[31] ^ b[31], a[30:0]};
            default: begin
`ifdef SIGN_INJECT_CLASS_EN
                e.res = {22'd0, cls(a)};
`else
                e.ill = 1'b1;
`endif
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic s;
        s = 1'($urandom);
        case ($urandom % 7)
            0: return {s, 8'hFF, 23'h0};
            1: return {s, 8'hFF, 1'b1, 22'($urandom)};
            2: return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 32'h3FFFFF))};
            3: return {s, 31'h0};
            4: return {s, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: occupancy, ordering and presented-entry stability.
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
            check("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
            if (out_valid && q.size() != 0) begin
                check("result", {32'd0, out_result}, {32'd0, q[0].res});
                check("tag", {60'd0, out_tag}, {60'd0, q[0].tag});
                check("illegal", {63'd0, out_illegal}, {63'd0, q[0].ill});
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready)
                q.push_back(model(in_a, in_b, in_op, in_tag));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [3:0] tag);
        bit ok;
        ok = 1'b0;
        in_a = a;
        in_b = b;
        in_op = op;
        in_tag = tag;
        in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    logic [63:0] cls_exp [3];
    logic        cls_ill;

    initial begin
        @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_result", {32'd0, out_result}, 64'd0);
        check("rst_tag", {60'd0, out_tag}, 64'd0);
        check("rst_illegal", {63'd0, out_illegal}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        out_ready = 1'b1;
        issue(32'h3F800000, 32'hC0000000, 2'd0, 4'd5);
        check("sgnj", {32'd0, out_result}, 64'hBF800000);
        check("sgnj_tag", {60'd0, out_tag}, 64'd5);
        issue(32'h3F800000, 32'hC0000000, 2'd1, 4'd6);
        check("sgnjn", {32'd0, out_result}, 64'h3F800000);
        check("sgnjn_tag", {60'd0, out_tag}, 64'd6);
        issue(32'h3F800000, 32'hC0000000, 2'd2, 4'd7);
        check("sgnjx", {32'd0, out_result}, 64'hBF800000);
        check("sgnjx_tag", {60'd0, out_tag}, 64'd7);

`ifdef SIGN_INJECT_CLASS_EN
        cls_exp[0] = 64'h200; cls_exp[1] = 64'h001; cls_exp[2] = 64'h020;
        cls_ill = 1'b0;
`else
        cls_exp[0] = 64'h0; cls_exp[1] = 64'h0; cls_exp[2] = 64'h0;
        cls_ill = 1'b1;
`endif
        issue(32'h7FC00000, 32'h0, 2'd3, 4'd8);
        check("class_qnan", {32'd0, out_result}, cls_exp[0]);
        check("class_ill", {63'd0, out_illegal}, {63'd0, cls_ill});
        issue(32'hFF800000, 32'h0, 2'd3, 4'd9);
        check("class_ninf", {32'd0, out_result}, cls_exp[1]);
        issue(32'h00000001, 32'h0, 2'd3, 4'd10);
        check("class_psub", {32'd0, out_result}, cls_exp[2]);
        drain();

        out_ready = 1'b0;
        issue(rnd_fp(), rnd_fp(), 2'($urandom), 4'd1);
        issue(rnd_fp(), rnd_fp(), 2'($urandom), 4'd2);
        in_a = rnd_fp();
        in_b = rnd_fp();
        in_op = 2'($urandom);
        in_tag = 4'd3;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_head_tag", {60'd0, out_tag}, 64'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue(in_a, in_b, in_op, 4'd3);
        drain();

        out_ready = 1'b1;
        issue(rnd_fp(), rnd_fp(), 2'($urandom), 4'd0);
        for (int i = 0; i < 8; i++) begin
            issue(rnd_fp(), rnd_fp(), 2'($urandom), 4'(i + 1));
            check("half_valid", {63'd0, out_valid}, 64'd1);
        end
        drain();

        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom % 3) != 0;
            if ($urandom % 5 == 0) begin
                @(posedge clk);
                #1;
            end
            issue(rnd_fp(), rnd_fp(), 2'($urandom), 4'($urandom));
        end
        drain();
        check("drained", 64'(q.size()), 64'd0);

        out_ready = 1'b0;
        issue(rnd_fp(), rnd_fp(), 2'd0, 4'd11);
        issue(rnd_fp(), rnd_fp(), 2'd1, 4'd12);
        #1 rst = 1'b1;
        q.delete();
        #1;
        check("frst_out_valid", {63'd0, out_valid}, 64'd0);
        check("frst_in_ready", {63'd0, in_ready}, 64'd1);
        check("frst_result", {32'd0, out_result}, 64'd0);
        check("frst_tag", {60'd0, out_tag}, 64'd0);
        check("frst_illegal", {63'd0, out_illegal}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        issue(32'h40490FDB, 32'h80000000, 2'd2, 4'd13);
        check("post_rst_res", {32'd0, out_result}, 64'hC0490FDB);
        drain();

        d_in_a = 64'h3FF0000000000000;
        d_in_b = 64'h8000000000000000;
        d_in_op = 2'd0;
        d_in_tag = 4'd4;
        d_in_valid = 1'b1;
        @(posedge clk);
        #1 d_in_valid = 1'b0;
        check("dbl_valid", {63'd0, d_out_valid}, 64'd1);
        check("dbl_result", d_out_result, 64'hBFF0000000000000);
        check("dbl_tag", {60'd0, d_out_tag}, 64'd4);
        check("dbl_illegal", {63'd0, d_out_illegal}, 64'd0);
        @(posedge clk);
        #1;
        check("dbl_empty", {63'd0, d_out_valid}, 64'd0);
        check("dbl_ready", {63'd0, d_in_ready}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
